// File: rtl/vu_frame_renderer.sv
// Two-channel VU-meter renderer placed directly behind vga_controller.
// Takes one left/right level pair per frame during vertical blank over a
// valid/ready handshake, keeps a per-channel peak-hold with decay, and draws
// two vertical bars with peak markers as 12-bit RGB. Sync and enable are
// re-timed by one clock so they line up with the registered pixel colour.
//
// Ports:
//   pixel_clock, reset          clock, synchronous active-low reset
//   h_sync_in, v_sync_in,
//   disp_enable_in, row, column  raster timing from vga_controller
//   lvl_l, lvl_r, lvl_valid      level pair offered once per frame
//   lvl_ready                    renderer is waiting for a level pair
//   h_sync, v_sync, disp_enable  timing delayed by one clock
//   rgb                          {R,G,B} nibbles, aligned with disp_enable
//   peak_l, peak_r               current peak-hold values
module vu_frame_renderer #(
   parameter int unsigned C_SIZE    = 10,
   parameter int unsigned LVL_W     = 9,
   parameter int unsigned H_ACT     = 640,
   parameter int unsigned V_ACT     = 480,
   parameter int unsigned BAR_X0    = 160,
   parameter int unsigned BAR_X1    = 400,
   parameter int unsigned BAR_W     = 80,
   parameter int unsigned YEL_TH    = 320,
   parameter int unsigned RED_TH    = 420,
   parameter int unsigned PEAK_HOLD = 30,
   parameter int unsigned DECAY     = 4,
   parameter bit          H_POL     = 1'b0,
   parameter bit          V_POL     = 1'b0
) (
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   input  logic              disp_enable_in,
   input  logic [C_SIZE:0]   row,
   input  logic [C_SIZE:0]   column,
   input  logic [LVL_W-1:0]  lvl_l,
   input  logic [LVL_W-1:0]  lvl_r,
   input  logic              lvl_valid,
   output logic              lvl_ready,
   output logic              h_sync,
   output logic              v_sync,
   output logic              disp_enable,
   output logic [11:0]       rgb,
   output logic [LVL_W-1:0]  peak_l,
   output logic [LVL_W-1:0]  peak_r
);

   localparam int unsigned HOLD_W = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;

   typedef enum logic [1:0] {S_WAIT_VS, S_LOAD, S_UPDATE} state_t;

   state_t             state;
   logic               vs_act_q;
   logic               de_in_q;
   logic [LVL_W-1:0]   disp_l;
   logic [LVL_W-1:0]   disp_r;
   logic [HOLD_W-1:0]  hold_l;
   logic [HOLD_W-1:0]  hold_r;
   logic               vs_act_c;
   logic [11:0]        pix_c;

   // Levels taller than the screen are clipped to the screen height.
   function automatic logic [LVL_W-1:0] clip_lvl(input logic [LVL_W-1:0] v);
      if (32'(v) > V_ACT) return LVL_W'(V_ACT);
      return v;
   endfunction

   // One frame of peak-hold: new maximum reloads hold, else hold runs out, then decay.
   function automatic logic [LVL_W+HOLD_W-1:0] peak_step(input logic [LVL_W-1:0]  lvl,
                                                         input logic [LVL_W-1:0]  peak,
                                                         input logic [HOLD_W-1:0] hold);
      logic [LVL_W-1:0] dec;
      if (lvl >= peak) return {lvl, HOLD_W'(PEAK_HOLD)};
      if (hold != '0) return {peak, hold - HOLD_W'(1)};
      dec = (32'(peak) > DECAY) ? peak - LVL_W'(DECAY) : '0;
      return {((dec > lvl) ? dec : lvl), hold};
   endfunction

   function automatic logic in_bar(input logic [C_SIZE:0] col, input int unsigned x0);
      logic [31:0] c32;
      c32 = 32'(col);
      return (c32 >= x0) && (c32 < x0 + BAR_W) && (c32 < H_ACT);
   endfunction

   // Colour of one pixel inside a bar column; height is counted up from the bottom row.
   function automatic logic [11:0] bar_pixel(input logic [C_SIZE:0]  r,
                                             input logic [LVL_W-1:0] lvl,
                                             input logic [LVL_W-1:0] peak);
      logic [31:0] row32;
      logic [31:0] h;
      row32 = 32'(r);
      h     = V_ACT - row32;
      if ((peak != '0) && (row32 == V_ACT - 32'(peak))) return 12'hFFF;
      if (row32 >= V_ACT - 32'(lvl)) begin
         if (h > RED_TH) return 12'hF00;
         if (h > YEL_TH) return 12'hFF0;
         return 12'h0F0;
      end
      return 12'h000;
   endfunction

   assign vs_act_c = (v_sync_in == V_POL);

   // Pixel colour for the current raster position; left bar wins on overlap.
   always_comb begin
      pix_c = 12'h000;
      if (disp_enable_in) begin
         if (in_bar(column, BAR_X0))      pix_c = bar_pixel(row, disp_l, peak_l);
         else if (in_bar(column, BAR_X1)) pix_c = bar_pixel(row, disp_r, peak_r);
      end
   end

   // Level scheduler FSM, peak state and output re-timing.
   always_ff @(posedge pixel_clock) begin
      if (!reset) begin
         state       <= S_WAIT_VS;
         vs_act_q    <= 1'b1;   // a fresh inactive-to-active edge is needed after reset
         de_in_q     <= 1'b0;
         lvl_ready   <= 1'b0;
         h_sync      <= !H_POL;
         v_sync      <= !V_POL;
         disp_enable <= 1'b0;
         rgb         <= 12'h000;
         disp_l      <= '0;
         disp_r      <= '0;
         peak_l      <= '0;
         peak_r      <= '0;
         hold_l      <= '0;
         hold_r      <= '0;
      end else begin
         vs_act_q    <= vs_act_c;
         de_in_q     <= disp_enable_in;
         h_sync      <= h_sync_in;
         v_sync      <= v_sync_in;
         disp_enable <= disp_enable_in;
         rgb         <= pix_c;
         case (state)
            S_WAIT_VS: begin
               if (vs_act_c && !vs_act_q) begin
                  state     <= S_LOAD;
                  lvl_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               if (lvl_valid && lvl_ready) begin
                  disp_l    <= clip_lvl(lvl_l);
                  disp_r    <= clip_lvl(lvl_r);
                  lvl_ready <= 1'b0;
                  state     <= S_UPDATE;
               end else if (disp_enable_in && !de_in_q) begin
                  // Active video began without a sample: reuse the previous levels.
                  lvl_ready <= 1'b0;
                  state     <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               {peak_l, hold_l} <= peak_step(disp_l, peak_l, hold_l);
               {peak_r, hold_r} <= peak_step(disp_r, peak_r, hold_r);
               state            <= S_WAIT_VS;
            end
            default: state <= S_WAIT_VS;
         endcase
      end
   end

endmodule

// File: tb/tb_vu_frame_renderer.sv
// Directed bench for vu_frame_renderer on a 4x4 raster. Raster outputs are
// predicted by a scoreboard fed from a small behavioural model of the meter.
module tb_vu_frame_renderer;

   localparam int C_SIZE    = 10;
   localparam int CW        = C_SIZE + 1;
   localparam int LVL_W     = 9;
   localparam int H_ACT     = 4;
   localparam int V_ACT     = 4;
   localparam int BAR_X0    = 0;
   localparam int BAR_X1    = 2;
   localparam int BAR_W     = 2;
   localparam int YEL_TH    = 2;
   localparam int RED_TH    = 3;
   localparam int PEAK_HOLD = 2;
   localparam int DECAY     = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              h_sync_in, v_sync_in, disp_enable_in;
   logic [CW-1:0]     row, column;
   logic [LVL_W-1:0]  lvl_l, lvl_r;
   logic              lvl_valid;
   logic              lvl_ready;
   logic              h_sync, v_sync, disp_enable;
   logic [11:0]       rgb;
   logic [LVL_W-1:0]  peak_l, peak_r;

   typedef struct packed {
      logic        h;
      logic        v;
      logic        de;
      logic [11:0] rgb;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_lvl[2];
   int   m_peak[2];
   int   m_hold[2];
   int   seq[6] = '{3, 3, 3, 2, 1, 0};

   always #5 clk = ~clk;

   vu_frame_renderer #(
      .C_SIZE(C_SIZE), .LVL_W(LVL_W), .H_ACT(H_ACT), .V_ACT(V_ACT),
      .BAR_X0(BAR_X0), .BAR_X1(BAR_X1), .BAR_W(BAR_W),
      .YEL_TH(YEL_TH), .RED_TH(RED_TH), .PEAK_HOLD(PEAK_HOLD), .DECAY(DECAY),
      .H_POL(1'b0), .V_POL(1'b0)
   ) dut (
      .pixel_clock(clk), .reset(reset),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_enable_in(disp_enable_in),
      .row(row), .column(column),
      .lvl_l(lvl_l), .lvl_r(lvl_r), .lvl_valid(lvl_valid), .lvl_ready(lvl_ready),
      .h_sync(h_sync), .v_sync(v_sync), .disp_enable(disp_enable),
      .rgb(rgb), .peak_l(peak_l), .peak_r(peak_r)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_pix(input logic de, input int r, input int c);
      int ch;
      int h;
      if (!de || c >= H_ACT) return 0;
      ch = -1;
      if (c >= BAR_X0 && c < BAR_X0 + BAR_W)      ch = 0;
      else if (c >= BAR_X1 && c < BAR_X1 + BAR_W) ch = 1;
      if (ch < 0) return 0;
      if (m_peak[ch] > 0 && r == V_ACT - m_peak[ch]) return 'hFFF;
      if (r >= V_ACT - m_lvl[ch]) begin
         h = V_ACT - r;
         if (h > RED_TH) return 'hF00;
         if (h > YEL_TH) return 'hFF0;
         return 'h0F0;
      end
      return 0;
   endfunction

   task automatic model_capture(input int l, input int r);
      m_lvl[0] = (l > V_ACT) ? V_ACT : l;
      m_lvl[1] = (r > V_ACT) ? V_ACT : r;
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         if (m_lvl[i] >= m_peak[i]) begin
            m_peak[i] = m_lvl[i];
            m_hold[i] = PEAK_HOLD;
         end else if (m_hold[i] > 0) begin
            m_hold[i]--;
         end else begin
            m_peak[i] = (m_peak[i] > DECAY) ? m_peak[i] - DECAY : 0;
            if (m_peak[i] < m_lvl[i]) m_peak[i] = m_lvl[i];
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = 0; m_peak[i] = 0; m_hold[i] = 0;
      end
   endtask

   // One pixel clock: drive raster inputs, predict, then compare one clock later.
   task automatic step(input logic h, input logic v, input logic de, input int r, input int c);
      exp_t e;
      h_sync_in      = h;
      v_sync_in      = v;
      disp_enable_in = de;
      row            = CW'(r);
      column         = CW'(c);
      e.h   = h;
      e.v   = v;
      e.de  = de;
      e.rgb = 12'(exp_pix(de, r, c));
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("h_sync", 32'(h_sync), 32'(e.h));
      chk("v_sync", 32'(v_sync), 32'(e.v));
      chk("disp_enable", 32'(disp_enable), 32'(e.de));
      chk($sformatf("rgb r%0d c%0d", r, c), 32'(rgb), 32'(e.rgb));
   endtask

   // One frame: vblank with an optional level pair, then a fully checked active area.
   task automatic frame(input bit send, input int l, input int r);
      bit pending;
      int n;
      lvl_valid = 1'b0;
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      step(1'b1, 1'b0, 1'b0, 0, H_ACT);
      chk("ready_after_vs", 32'(lvl_ready), 32'd1);
      pending = !send;
      if (send) begin
         lvl_l     = LVL_W'(l);
         lvl_r     = LVL_W'(r);
         lvl_valid = 1'b1;
         step(1'b1, 1'b0, 1'b0, 0, H_ACT);
         chk("ready_drop", 32'(lvl_ready), 32'd0);
         lvl_valid = 1'b0;
         model_capture(l, r);
         model_update();
         step(1'b1, 1'b0, 1'b0, 0, H_ACT);
         chk("peak_l_upd", 32'(peak_l), 32'(m_peak[0]));
         chk("peak_r_upd", 32'(peak_r), 32'(m_peak[1]));
      end else begin
         step(1'b1, 1'b0, 1'b0, 0, H_ACT);
         step(1'b1, 1'b0, 1'b0, 0, H_ACT);
         chk("ready_held", 32'(lvl_ready), 32'd1);
      end
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      n = 0;
      for (int y = 0; y < V_ACT; y++) begin
         for (int x = 0; x < H_ACT; x++) begin
            // Without a sample the update lands during the second active pixel.
            if (pending && n == 2) begin
               model_update();
               pending = 1'b0;
            end
            step(1'b1, 1'b1, 1'b1, y, x);
            if (n == 0) chk("ready_active", 32'(lvl_ready), 32'd0);
            n++;
         end
         step(1'b0, 1'b1, 1'b0, y, H_ACT);
         step(1'b1, 1'b1, 1'b0, y, H_ACT);
      end
      chk("peak_l_end", 32'(peak_l), 32'(m_peak[0]));
      chk("peak_r_end", 32'(peak_r), 32'(m_peak[1]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset          = 1'b0;
      h_sync_in      = 1'b0;
      v_sync_in      = 1'b0;
      disp_enable_in = 1'b1;
      row            = '0;
      column         = '0;
      lvl_l          = '0;
      lvl_r          = '0;
      lvl_valid      = 1'b1;

      // Reset held for three clocks with arbitrary inputs.
      for (int i = 0; i < 3; i++) begin
         h_sync_in      = 1'($urandom);
         v_sync_in      = 1'($urandom);
         disp_enable_in = 1'($urandom);
         row            = CW'($urandom_range(0, 3));
         column         = CW'($urandom_range(0, 3));
         lvl_l          = LVL_W'($urandom);
         lvl_r          = LVL_W'($urandom);
         @(posedge clk);
         #1;
      end
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_ready", 32'(lvl_ready), 32'd0);
      chk("rst_de", 32'(disp_enable), 32'd0);
      chk("rst_hs", 32'(h_sync), 32'd1);
      chk("rst_vs", 32'(v_sync), 32'd1);
      chk("rst_peak_l", 32'(peak_l), 32'd0);
      chk("rst_peak_r", 32'(peak_r), 32'd0);

      reset     = 1'b1;
      lvl_valid = 1'b0;
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);

      // Handshake L=3 R=1 and render it in the same frame's active area.
      frame(1'b1, 3, 1);
      chk("peak_l_3", 32'(peak_l), 32'd3);
      chk("peak_r_1", 32'(peak_r), 32'd1);

      // No sample: leaves S_LOAD on the first active pixel.
      frame(1'b0, 0, 0);

      // Hold two frames, then decay by one per frame.
      frame(1'b1, 3, 0);
      chk("hold_seq", 32'(peak_l), 32'(seq[0]));
      for (int i = 1; i < 6; i++) begin
         frame(1'b1, 0, 0);
         chk("hold_seq", 32'(peak_l), 32'(seq[i]));
      end

      // Levels taller than the screen clip to V_ACT.
      frame(1'b1, 9, 4);
      chk("clip_l", 32'(peak_l), 32'd4);
      chk("clip_r", 32'(peak_r), 32'd4);

      // Reset while a level pair is being offered in S_LOAD.
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      step(1'b1, 1'b1, 1'b0, 0, H_ACT);
      step(1'b1, 1'b0, 1'b0, 0, H_ACT);
      chk("ready_pre_rst", 32'(lvl_ready), 32'd1);
      lvl_l     = LVL_W'(2);
      lvl_r     = LVL_W'(2);
      lvl_valid = 1'b1;
      reset     = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", 32'(lvl_ready), 32'd0);
      chk("midrst_peak_l", 32'(peak_l), 32'd0);
      chk("midrst_peak_r", 32'(peak_r), 32'd0);
      chk("midrst_rgb", 32'(rgb), 32'd0);
      reset     = 1'b1;
      lvl_valid = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 1'b0, 0, H_ACT);
      step(1'b1, 1'b0, 1'b0, 0, H_ACT);
      chk("wait_vs_after_rst", 32'(lvl_ready), 32'd0);

      // Nothing was captured: a sample-less frame keeps everything at zero.
      frame(1'b0, 0, 0);
      chk("post_rst_peak_l", 32'(peak_l), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
